// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding, parameter limits and
// the burst-counter width helper.
package fifo_arb_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  localparam int unsigned NumReqMin   = 2;
  localparam int unsigned NumReqMax   = 8;
  localparam int unsigned BurstMaxMin = 1;
  localparam int unsigned BurstMaxMax = 16;

  // Counter must be able to hold the value burst_max itself.
  function automatic int unsigned cnt_width(input int unsigned burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO-side signal bundle of the write arbiter.
// slave: arbiter side; master: requesters/FIFO/integration side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);

  localparam int unsigned OwnerW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       i_Req;
  logic [NUM_REQ*WIDTH-1:0] i_Data;
  logic [NUM_REQ-1:0]       i_Last;
  logic [NUM_REQ-1:0]       o_Ack;
  logic                     o_Wr_DV;
  logic [WIDTH-1:0]         o_Wr_Data;
  logic                     i_Full;
  logic                     i_AF_Flag;
  logic [OwnerW-1:0]        o_Owner;
  logic                     o_Busy;

  modport slave (
    input  i_Req, i_Data, i_Last, i_Full, i_AF_Flag,
    output o_Ack, o_Wr_DV, o_Wr_Data, o_Owner, o_Busy
  );

  modport master (
    output i_Req, i_Data, i_Last, i_Full, i_AF_Flag,
    input  o_Ack, o_Wr_DV, o_Wr_Data, o_Owner, o_Busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting index strictly after the last
// owner, searching upward and wrapping from NUM_REQ-1 to 0.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_Req,
  input  logic [$clog2(NUM_REQ)-1:0] i_Last_Owner,
  output logic [$clog2(NUM_REQ)-1:0] o_Winner,
  output logic                       o_Found
);

  localparam int unsigned OwnerW = $clog2(NUM_REQ);

  logic [31:0]       idx;
  logic [OwnerW-1:0] idx_w;

  // Scan offsets 1..NUM_REQ so the last owner itself is considered last.
  always_comb begin
    o_Winner = '0;
    o_Found  = 1'b0;
    idx      = '0;
    idx_w    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx   = (32'(i_Last_Owner) + k) % NUM_REQ;
      idx_w = idx[OwnerW-1:0];
      if (!o_Found && i_Req[idx_w]) begin
        o_Winner = idx_w;
        o_Found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ word streams into one FIFO write port.
// A grant lasts until i_Last, BURST_MAX words, or the owner dropping its request.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input logic               i_Clk,
  input logic               i_Rst_L,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int unsigned       OwnerW  = $clog2(NUM_REQ);
  localparam int unsigned       CntW    = cnt_width(BURST_MAX);
  localparam logic [CntW-1:0]   CntMax  = CntW'(BURST_MAX);
  localparam logic [OwnerW-1:0] LastRst = OwnerW'(NUM_REQ - 1);

  if (BURST_MAX < BurstMaxMin || BURST_MAX > BurstMaxMax) begin : g_bad_burst_max
    $error("fifo_wr_arbiter: BURST_MAX out of range");
  end
  if (NUM_REQ < NumReqMin || NUM_REQ > NumReqMax) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ out of range");
  end

  arb_state_e        state_q, state_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [OwnerW-1:0] last_q, last_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              wr_dv_q, wr_dv_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;

  logic [OwnerW-1:0] winner;
  logic              found;
  logic              own_req, own_last, ack_any;
  logic [WIDTH-1:0]  own_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_Req        (bus.i_Req),
    .i_Last_Owner (last_q),
    .o_Winner     (winner),
    .o_Found      (found)
  );

  // Select the current owner's request, last flag and word.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int unsigned n = 0; n < NUM_REQ; n++) begin
      if (owner_q == OwnerW'(n)) begin
        own_req  = bus.i_Req[n];
        own_last = bus.i_Last[n];
        own_data = bus.i_Data[n*WIDTH +: WIDTH];
      end
    end
  end

  // Full stalls the owner in place; it never ends the burst.
  assign ack_any = (state_q == StBurst) && own_req && !bus.i_Full;

  // One-hot ack to the owner only.
  always_comb begin
    bus.o_Ack = '0;
    for (int unsigned n = 0; n < NUM_REQ; n++) begin
      bus.o_Ack[n] = ack_any && (owner_q == OwnerW'(n));
    end
  end

  // FSM next state, grant loading and burst counting.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CntW'(1);
    unique case (state_q)
      StIdle: begin
        // Almost-full only blocks new grants.
        if (found && !bus.i_Full && !bus.i_AF_Flag) begin
          state_d = StBurst;
          owner_d = winner;
          cnt_d   = '0;
        end
      end
      StBurst: begin
        if (!own_req) begin
          state_d = StIdle;
          last_d  = owner_q;
        end else if (ack_any) begin
          cnt_d = cnt_inc;
          if (own_last || cnt_inc == CntMax) begin
            state_d = StIdle;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write port runs one cycle behind the ack; data holds between writes.
  always_comb begin
    wr_dv_d   = ack_any;
    wr_data_d = ack_any ? own_data : wr_data_q;
  end

  // State registers; reset parks the pointer so requester 0 wins first.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      last_q    <= LastRst;
      cnt_q     <= '0;
      wr_dv_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      wr_dv_q   <= wr_dv_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.o_Wr_DV   = wr_dv_q;
  assign bus.o_Wr_Data = wr_data_q;
  assign bus.o_Owner   = owner_q;
  assign bus.o_Busy    = (state_q == StBurst);

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter WIDTH, default 8, data word width, equal to the downstream FIFO WIDTH.
REQ-003 Parameter BURST_MAX, default 4, maximum words accepted per grant (1..16).
REQ-004 i_Clk  input  1  clock; all state SHALL change on its rising edge.
REQ-005 i_Rst_L  input  1  reset, asynchronous, active-low.
REQ-006 i_Req  input  NUM_REQ  per-requester word-valid; requester SHALL hold the word stable until acked.
REQ-007 i_Data  input  NUM_REQ*WIDTH  requester words, requester n at bits [n*WIDTH +: WIDTH].
REQ-008 i_Last  input  NUM_REQ  marks the current word as the last of a requester's burst.
REQ-009 o_Ack  output  NUM_REQ  one-hot word-accepted strobe; requester may present its next word the following cycle.
REQ-010 o_Wr_DV  output  1  write strobe to the FIFO write port.
REQ-011 o_Wr_Data  output  WIDTH  write data to the FIFO write port.
REQ-012 i_Full  input  1  FIFO full flag, including the FIFO's same-cycle write lookahead.
REQ-013 i_AF_Flag  input  1  FIFO almost-full flag.
REQ-014 o_Owner  output  $clog2(NUM_REQ)  index of the current grant holder.
REQ-015 o_Busy  output  1  high while in the BURST state.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and BURST.
REQ-017 IDLE: if any i_Req is high, i_Full=0 and i_AF_Flag=0, the block SHALL select a winner, load o_Owner and go to BURST next cycle; otherwise it SHALL stay in IDLE.
REQ-018 Winner selection SHALL be round-robin: the first requesting index after the last owner, searching upward with wrap from NUM_REQ-1 to 0.
REQ-019 o_Ack[n] SHALL be combinational: high only when state=BURST, o_Owner=n, i_Req[n]=1 and i_Full=0.
REQ-020 On every ack, o_Wr_DV SHALL be 1 and o_Wr_Data SHALL equal the acked word in the next cycle (latency 1); otherwise o_Wr_DV SHALL be 0.
REQ-021 o_Wr_Data SHALL hold its last value when o_Wr_DV=0.
REQ-022 Burst word counter: clear on entry to BURST, increment by 1 per ack, width $clog2(BURST_MAX+1).
REQ-023 BURST SHALL exit to IDLE after any of these events:
- an ack with i_Last high;
- the ack that makes the counter reach BURST_MAX;
- a cycle where the owner's i_Req is 0.
REQ-024 i_Full=1 during BURST SHALL pause acks without ending the burst, provided the owner's i_Req stays high.
REQ-025 i_AF_Flag SHALL block only new grants and SHALL NOT truncate a burst in progress.
REQ-026 When the exit conditions coincide (i_Last with the BURST_MAX-th ack), the block SHALL perform one exit; the last-owner pointer SHALL update to o_Owner.
REQ-027 Each grant SHALL be followed by one IDLE cycle before the next grant (arbitration bubble).
REQ-028 i_Req from non-owners during BURST SHALL be ignored and SHALL NOT be acked.
REQ-029 The block SHALL never drive o_Wr_DV=1 in a cycle after sampling i_Full=1 for that word.

Reset
REQ-030 Asserting i_Rst_L low at any time, including mid-burst, SHALL immediately force:
- state=IDLE;
- o_Wr_DV=0, o_Wr_Data=0;
- o_Owner=0, o_Busy=0;
- burst counter=0;
- last-owner pointer=NUM_REQ-1, so requester 0 wins first.
REQ-031 o_Ack SHALL be all-zero while reset is asserted; a word in flight at reset SHALL be lost, with no recovery.

Structure
REQ-032 The state encoding and the BURST_MAX range limits SHALL reside in shared package fifo_arb_pkg.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_pick with inputs (request vector, last-owner index) and outputs (winner index, found).
REQ-034 The block SHALL NOT instantiate the FIFO; the integration level connects o_Wr_DV/o_Wr_Data/i_Full/i_AF_Flag.

Verification
REQ-035 Reset release, i_Req=4'b0001 with 3 words, i_Last on the 3rd -> 3 acks, 3 o_Wr_DV pulses with matching data one cycle later, then IDLE.
REQ-036 All four requesting continuously, BURST_MAX=4, i_Last=0 -> grants in order 0,1,2,3,0, 4 words each, one IDLE cycle between grants.
REQ-037 Owner 2 mid-burst, i_Full high for 5 cycles -> no acks and no o_Wr_DV during those cycles, burst resumes, total words per grant still 4.
REQ-038 Behind a real 8-deep FIFO, one requester streaming -> exactly 8 writes accepted; FIFO "Writing Full" error never fires; acks resume after one FIFO read.
REQ-039 i_Rst_L pulsed low mid-burst of requester 1 -> o_Wr_DV=0 and o_Ack=0 immediately; after release, requester 0 wins first.
REQ-040 i_AF_Flag high with requester 3 waiting -> no grant until i_AF_Flag falls; a burst in progress when i_AF_Flag rises completes to its i_Last.
